// File: rtl/uart_transmitter.sv
// 20-bit UART transmit end: frames each accepted message as {start=1, message MSB-first, stop=0}.
// The line idles low and every frame bit is held for CLKS_PER_BIT clocks.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [19:0] message,
  output logic        ready,
  output logic        serialOut,
  output logic        done
);

  localparam int              DIV_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]       BIT_LAST = 5'd21;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  state_t           state_next;
  logic [21:0]      shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic             div_term;
  logic             load;
  logic             shift;
  logic             finish;

  assign div_term = (div_cnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (send) state_next = SEND;
      SEND: if (div_term && (bit_cnt == BIT_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    shift  = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE: load = send;
      SEND: begin
        if (div_term) begin
          if (bit_cnt == BIT_LAST) finish = 1'b1;
          else                     shift  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control and line outputs: all registered, so nothing combinational reaches a port.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      ready     <= 1'b1;
      serialOut <= 1'b0;
      done      <= 1'b0;
    end else begin
      done  <= finish;
      ready <= (state_next == IDLE);
      if (load) begin
        div_cnt   <= '0;
        bit_cnt   <= '0;
        serialOut <= 1'b1;
      end else if (state == SEND) begin
        div_cnt <= div_term ? '0 : div_cnt + 1'b1;
        if (shift) begin
          bit_cnt   <= bit_cnt + 5'd1;
          serialOut <= shreg[20];
        end
        if (finish) begin
          bit_cnt   <= '0;
          serialOut <= 1'b0;
        end
      end
    end
  end

  // Frame data needs no reset; it rotates so every bit stays in use and the
  // vacated positions are simply never transmitted.
  always_ff @(posedge clock) begin
    if (load) begin
      shreg <= {1'b1, message, 1'b0};
    end else if (shift) begin
      shreg <= {shreg[20:0], shreg[21]};
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame content, bit timing, done/ready, busy
// rejection, back-to-back sends and reset in the middle of a frame.
module tb_uart_transmitter;

  localparam int C     = 8;
  localparam int FRAME = 22 * C;

  logic        clock = 1'b0;
  logic        reset;
  logic        send;
  logic [19:0] message;
  logic        ready;
  logic        serialOut;
  logic        done;

  int tests_run = 0;
  int fails     = 0;

  always #5 clock = ~clock;

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clock     (clock),
    .reset     (reset),
    .send      (send),
    .message   (message),
    .ready     (ready),
    .serialOut (serialOut),
    .done      (done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for ready, then raises send for exactly one edge; returns 1ns after edge T.
  task automatic start_send(input logic [19:0] m);
    for (int i = 0; i < 1000 && ready !== 1'b1; i++) @(negedge clock);
    tests_run++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_before_send: got %b want 1", ready);
    end
    @(posedge clock); #1;
    send = 1'b1; message = m;
    @(posedge clock); #1;
    send = 1'b0;
  endtask

  // Records the line for one frame starting just after edge T; samples on negedges.
  task automatic capture(output logic [21:0] bits, output int glitches, output int done_cnt,
                         output int ready_hi, output logic end_done, output logic end_ready,
                         output logic end_serial);
    bits = '0; glitches = 0; done_cnt = 0; ready_hi = 0;
    for (int n = 0; n < FRAME; n++) begin
      @(negedge clock);
      if (n % C == 0) bits[21 - n / C] = serialOut;
      else if (serialOut !== bits[21 - n / C]) glitches++;
      if (done === 1'b1) done_cnt++;
      if (ready !== 1'b0) ready_hi++;
    end
    @(negedge clock);
    end_done = done; end_ready = ready; end_serial = serialOut;
  endtask

  task automatic test_reset;
    int changes;
    reset = 1'b1; send = 1'b0; message = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    tests_run++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
    tests_run++; if (serialOut !== 1'b0) begin fails++; $display("FAIL reset_serial: got %b want 0", serialOut); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (ready !== 1'b1 || serialOut !== 1'b0 || done !== 1'b0) changes++;
    end
    tests_run++; if (changes != 0) begin fails++; $display("FAIL idle_hold: got %0d changes want 0", changes); end
    // reset and send on the same edge: reset wins
    @(posedge clock); #1;
    reset = 1'b1; send = 1'b1; message = 20'hFFFFF;
    @(posedge clock); #1;
    reset = 1'b0; send = 1'b0;
    @(negedge clock);
    tests_run++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_prio_ready: got %b want 1", ready); end
    @(negedge clock);
    tests_run++; if (serialOut !== 1'b0) begin fails++; $display("FAIL reset_prio_serial: got %b want 0", serialOut); end
  endtask

  task automatic test_single_frame;
    logic [21:0] bits; int gl, dc, rh; logic ed, er, es;
    start_send(20'hA5A5A);
    capture(bits, gl, dc, rh, ed, er, es);
    tests_run++; if (bits !== 22'h34B4B4) begin fails++; $display("FAIL single_bits: got %h want 34b4b4", bits); end
    tests_run++; if (gl != 0) begin fails++; $display("FAIL single_hold: got %0d glitches want 0", gl); end
    tests_run++; if (dc != 0) begin fails++; $display("FAIL single_early_done: got %0d want 0", dc); end
    tests_run++; if (rh != 0) begin fails++; $display("FAIL single_ready_low: got %0d high cycles want 0", rh); end
    tests_run++; if (ed !== 1'b1) begin fails++; $display("FAIL single_done_176: got %b want 1", ed); end
    tests_run++; if (er !== 1'b1) begin fails++; $display("FAIL single_ready_176: got %b want 1", er); end
    tests_run++; if (es !== 1'b0) begin fails++; $display("FAIL single_idle_line: got %b want 0", es); end
    @(negedge clock);
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_width: got %b want 0", done); end
  endtask

  task automatic test_back_to_back;
    logic [21:0] b1, b2; int g1, d1, r1, g2, d2, r2; logic ed1, er1, es1, ed2, er2, es2;
    int extra;
    @(posedge clock); #1;
    send = 1'b1; message = 20'h00001;
    @(posedge clock); #1;
    message = 20'hFFFFF;
    capture(b1, g1, d1, r1, ed1, er1, es1);
    capture(b2, g2, d2, r2, ed2, er2, es2);
    send = 1'b0;
    tests_run++; if (b1 !== 22'h200002) begin fails++; $display("FAIL b2b_first_bits: got %h want 200002", b1); end
    tests_run++; if (g1 != 0 || d1 != 0) begin fails++; $display("FAIL b2b_first_timing: got %0d/%0d want 0/0", g1, d1); end
    tests_run++; if (ed1 !== 1'b1 || es1 !== 1'b0) begin fails++; $display("FAIL b2b_first_end: got %b%b want 10", ed1, es1); end
    tests_run++; if (b2 !== 22'h3FFFFE) begin fails++; $display("FAIL b2b_second_bits: got %h want 3ffffe", b2); end
    tests_run++; if (g2 != 0 || d2 != 0 || r2 != 0) begin fails++; $display("FAIL b2b_second_timing: got %0d/%0d/%0d want 0/0/0", g2, d2, r2); end
    tests_run++; if (ed2 !== 1'b1) begin fails++; $display("FAIL b2b_second_done: got %b want 1", ed2); end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (serialOut !== 1'b0 || done !== 1'b0 || ready !== 1'b1) extra++;
    end
    tests_run++; if (extra != 0) begin fails++; $display("FAIL b2b_no_third: got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_busy_reject;
    logic [21:0] bits; int gl, dc, rh; logic ed, er, es;
    int extra;
    start_send(20'h0F0F0);
    fork
      capture(bits, gl, dc, rh, ed, er, es);
      begin
        repeat (39) @(posedge clock);
        #1 send = 1'b1; message = 20'h12345;
        @(posedge clock);
        #1 send = 1'b0;
      end
    join
    tests_run++; if (bits !== 22'h21E1E0) begin fails++; $display("FAIL busy_bits: got %h want 21e1e0", bits); end
    tests_run++; if (gl != 0 || dc != 0 || rh != 0) begin fails++; $display("FAIL busy_timing: got %0d/%0d/%0d want 0/0/0", gl, dc, rh); end
    tests_run++; if (ed !== 1'b1) begin fails++; $display("FAIL busy_done: got %b want 1", ed); end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (serialOut !== 1'b0 || done !== 1'b0 || ready !== 1'b1) extra++;
    end
    tests_run++; if (extra != 0) begin fails++; $display("FAIL busy_not_queued: got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_frame;
    logic [21:0] bits; int gl, dc, rh; logic ed, er, es;
    int bad;
    start_send(20'hFFFFF);
    repeat (99) @(posedge clock);
    @(negedge clock);
    tests_run++; if (serialOut !== 1'b1) begin fails++; $display("FAIL midreset_pre_line: got %b want 1", serialOut); end
    @(posedge clock); #1;   // edge T+100
    reset = 1'b1;
    @(posedge clock); #1;   // edge T+101 applies reset
    reset = 1'b0;
    @(negedge clock);
    tests_run++; if (serialOut !== 1'b0) begin fails++; $display("FAIL midreset_line: got %b want 0", serialOut); end
    tests_run++; if (ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", ready); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done: got %b want 0", done); end
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (serialOut !== 1'b0 || done !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL midreset_abandon: got %0d active cycles want 0", bad); end
    start_send(20'h55555);
    capture(bits, gl, dc, rh, ed, er, es);
    tests_run++; if (bits !== 22'h2AAAAA) begin fails++; $display("FAIL midreset_fresh_bits: got %h want 2aaaaa", bits); end
    tests_run++; if (gl != 0 || dc != 0 || ed !== 1'b1) begin fails++; $display("FAIL midreset_fresh_timing: got %0d/%0d/%b want 0/0/1", gl, dc, ed); end
  endtask

  task automatic test_loopback;
    logic [21:0] bits; int gl, dc, rh; logic ed, er, es;
    logic [19:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 20'($urandom);
      start_send(m);
      capture(bits, gl, dc, rh, ed, er, es);
      tests_run++;
      if (bits[21] !== 1'b1 || bits[0] !== 1'b0 || bits[20:1] !== m) begin
        fails++; $display("FAIL loopback_%0d: got %h want %h", k, bits, {1'b1, m, 1'b0});
      end
      tests_run++;
      if (gl != 0 || dc != 0 || ed !== 1'b1) begin
        fails++; $display("FAIL loopback_timing_%0d: got %0d/%0d/%b want 0/0/1", k, gl, dc, ed);
      end
    end
  endtask

  initial begin
    reset = 1'b1; send = 1'b0; message = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
